blit_cmd_arbiter: RTL and testbench
===================================

Name: blit_cmd_arbiter

Overview:
- Shares the single blitter command port between NUM_REQ requesters (CPU cores, DMA).
- Each requester has its own command FIFO.
- Arbitration is round-robin at command-group granularity. A granted requester keeps the blitter until a command marked last has been consumed, so its sticky blitter state (dest, clip, colour, offset, font) is never interleaved with another requester's commands.
- Sits between the memory-mapped command registers and the blitter's cmd/cmd_valid/next_cmd handshake.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DEPTH, 16, entries per requester FIFO (power of two)
HOLD_TIMEOUT, 1024, cycles a grant may sit with an empty FIFO and no last command before it is revoked

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high
req_cmd  input  NUM_REQ*96  per-requester command word; slice i = [96*i+95:96*i]; byte 0 = opcode, [63:32] = arg1, [95:64] = arg2
req_last  input  NUM_REQ  command closes the requester's group
req_push  input  NUM_REQ  write req_cmd/req_last into FIFO i
req_flush  input  NUM_REQ  empty FIFO i; revoke its grant
req_full  output  NUM_REQ  FIFO i full
req_level  output  NUM_REQ*5  FIFO i occupancy (0..DEPTH)
cmd  output  96  command to the blitter
cmd_valid  output  1  cmd is valid
next_cmd  input  1  blitter consumed cmd (single-cycle pulse)
grant_valid  output  1  a requester holds the blitter
grant_id  output  2  holder index
err_overflow  output  NUM_REQ  sticky: push to a full FIFO
err_timeout  output  NUM_REQ  sticky: grant revoked by timeout
err_protocol  output  1  sticky: next_cmd with cmd_valid low
err_clear  input  1  clears all sticky error bits

Behaviour:
- Reset: all FIFOs empty, state IDLE. cmd_valid=0, cmd=0, grant_valid=0, grant_id=0. rr pointer=0. All err_* =0, req_full=0, req_level=0.
- FIFO i:
  - Push and pop in the same cycle are allowed; the level is unchanged.
  - A push when full is dropped and sets err_overflow[i]. A pop in the same cycle does not make room for it.
  - req_full and req_level are registered and reflect the state after the current cycle's push/pop.
- State machine:
  - IDLE: scan requesters starting at rr, wrapping, for the first non-empty FIFO. On a hit, set grant_valid=1, grant_id=i, rr=i+1 mod NUM_REQ, then go to LOAD. Arbitration takes 1 cycle.
  - LOAD: if FIFO[grant_id] is non-empty, register its head into cmd, set cmd_valid=1, go to PRESENT. If it is empty, go to HOLD.
  - PRESENT: cmd and cmd_valid stay stable until next_cmd. On next_cmd:
    - pop FIFO[grant_id] and set cmd_valid=0 on the next edge;
    - if the popped entry had last=1, go to IDLE with grant_valid=0;
    - otherwise go to LOAD.
    - cmd_valid therefore drops for at least one cycle between commands, which matches the blitter's one-cycle settle.
  - HOLD: the grant is kept and the timeout counter increments each cycle.
    - A push to the granted FIFO goes to LOAD and clears the counter.
    - When the counter reaches HOLD_TIMEOUT-1: set err_timeout[grant_id], clear grant_valid, go to IDLE.
- Latency: a push into an empty FIFO while IDLE gives cmd_valid=1 three edges later (push, arbitrate, load).
- next_cmd while cmd_valid=0: ignored, sets err_protocol.
- req_flush[i]:
  - Empties FIFO i in that cycle; a simultaneous push to i is dropped without setting overflow.
  - If i is the holder and the state is PRESENT, cmd_valid stays 1 until next_cmd, then the FIFO is not popped and the state goes to IDLE. The blitter is mid-handshake and must not see cmd_valid withdraw.
  - If i is the holder in LOAD or HOLD: go straight to IDLE with grant_valid=0.
- err_clear and a new error event in the same cycle: the error event wins.
- Reset mid-operation: everything returns to reset values and FIFO contents are discarded. Any pending blitter handshake is abandoned; the blitter is reset together with this block.

Decomposition:
- Shared package blit_pkg:
  - BLIT_* opcode constants;
  - the command word typedef (opcode, arg1, arg2 field slices);
  - OP_* constants;
  - arbiter state enum {IDLE, LOAD, PRESENT, HOLD}.
- Sub-module blit_cmd_fifo: DEPTH x 97 bits (cmd + last), synchronous push/pop/flush, with full/empty/level outputs. Instantiated NUM_REQ times.

Test Plan:
- Single group: req0 pushes SET_COLOR(5,0) then RECT with last=1; bench pulses next_cmd 2 cycles after each cmd_valid rise -> cmd shows opcode 0x04 then 0x05; grant_id=0 throughout; grant_valid=0 after the second next_cmd.
- Group atomicity: req0 pushes 3 cmds (last on the 3rd); req1 pushes 1 cmd (last) one cycle later -> all 3 req0 commands are issued before req1's; grant_id changes 0 to 1 only after the 3rd next_cmd.
- Round-robin fairness: both requesters continuously push single-command groups -> grant_id alternates 0,1,0,1 over 8 groups.
- Hold timeout (HOLD_TIMEOUT=16): req0 pushes 1 cmd with last=0, then nothing; req1 has a pending command -> 16 cycles after entering HOLD, err_timeout[0]=1 and req1 is granted on the following arbitration.
- Overflow and flush: push 17 entries to req0 (DEPTH=16) -> err_overflow[0]=1, req_level=16; assert req_flush[0] while in PRESENT -> cmd_valid holds until next_cmd, then req_level=0 and grant_valid=0.
- Protocol error and reset: pulse next_cmd with cmd_valid=0 -> err_protocol=1; assert reset mid-group -> all outputs return to reset values and err_protocol=0.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared definitions for the blitter command path: opcodes, command word
// layout, FIFO entry format and the arbiter state encoding.
package blit_pkg;

    localparam int CMD_W = 96;
    localparam int LVL_W = 5;

    // Blitter opcodes (byte 0 of the command word)
    localparam logic [7:0] BLIT_NOP        = 8'h00;
    localparam logic [7:0] BLIT_SET_DEST   = 8'h01;
    localparam logic [7:0] BLIT_SET_CLIP   = 8'h02;
    localparam logic [7:0] BLIT_SET_OFFSET = 8'h03;
    localparam logic [7:0] BLIT_SET_COLOR  = 8'h04;
    localparam logic [7:0] BLIT_RECT       = 8'h05;
    localparam logic [7:0] BLIT_SET_FONT   = 8'h06;
    localparam logic [7:0] BLIT_TEXT       = 8'h07;

    // Field positions inside the 96-bit command word
    localparam int OP_OPCODE_LSB = 0;
    localparam int OP_ARG1_LSB   = 32;
    localparam int OP_ARG2_LSB   = 64;

    typedef struct packed {
        logic [31:0] arg2;
        logic [31:0] arg1;
        logic [23:0] rsvd;
        logic [7:0]  opcode;
    } blit_cmd_t;

    typedef struct packed {
        logic      last;
        blit_cmd_t cmd;
    } fifo_entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT, HOLD} arb_state_t;

    function automatic blit_cmd_t make_cmd(input logic [7:0] op, input logic [31:0] a1,
                                           input logic [31:0] a2);
        blit_cmd_t c;
        c.opcode = op;
        c.rsvd   = '0;
        c.arg1   = a1;
        c.arg2   = a2;
        return c;
    endfunction

endpackage

// File: rtl/blit_cmd_fifo.sv
// Per-requester command FIFO: DEPTH entries of {last, cmd}. Flush beats push
// and pop; a push into a full FIFO is dropped and reported on overflow_o.
module blit_cmd_fifo
    import blit_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fifo_entry_t      wdata_i,
    output fifo_entry_t      head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o,
    output logic             overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q;
    logic             do_push, do_pop;

    // Full is judged on the registered flag, so a same-cycle pop never makes room
    assign do_push    = push_i && !flush_i && !full_q;
    assign do_pop     = pop_i && !flush_i && (level_q != '0);
    assign overflow_o = push_i && !flush_i && full_q;

    // The head is read straight from the array; the arbiter's cmd register is the output stage
    assign head_o  = mem[rd_ptr_q];
    assign empty_o = (level_q == '0);
    assign full_o  = full_q;
    assign level_o = level_q;

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end

    // Pointer, level and full-flag registers
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == FULL_LVL);
        end
    end

endmodule

// File: rtl/blit_cmd_arbiter.sv
// Round-robin arbiter sharing the blitter command port between NUM_REQ
// requesters. A grant lasts for a whole command group (up to a command marked
// last) so sticky blitter state from different requesters never interleaves.
module blit_cmd_arbiter
    import blit_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DEPTH        = 16,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ*96-1:0]    req_cmd,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ-1:0]       req_push,
    input  logic [NUM_REQ-1:0]       req_flush,
    output logic [NUM_REQ-1:0]       req_full,
    output logic [NUM_REQ*5-1:0]     req_level,
    output logic [95:0]              cmd,
    output logic                     cmd_valid,
    input  logic                     next_cmd,
    output logic                     grant_valid,
    output logic [1:0]               grant_id,
    output logic [NUM_REQ-1:0]       err_overflow,
    output logic [NUM_REQ-1:0]       err_timeout,
    output logic                     err_protocol,
    input  logic                     err_clear
);

    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(HOLD_TIMEOUT - 1);

    fifo_entry_t        head [NUM_REQ];
    logic [NUM_REQ-1:0] fifo_empty, fifo_ovf, fifo_pop, avail, timeout_ev;

    arb_state_t         state_q, state_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDW-1:0]     grant_q, grant_d, rr_q, rr_d, pick, idx;
    blit_cmd_t          cmd_q, cmd_d;
    logic               last_q, last_d, cmd_valid_q, cmd_valid_d;
    logic               flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit;
    logic [NUM_REQ-1:0] err_overflow_q, err_timeout_q;
    logic               err_protocol_q;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
            fifo_entry_t wdata;
            assign wdata = {req_last[gi], req_cmd[gi*CMD_W +: CMD_W]};

            blit_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clock      (clock),
                .reset      (reset),
                .push_i     (req_push[gi]),
                .pop_i      (fifo_pop[gi]),
                .flush_i    (req_flush[gi]),
                .wdata_i    (wdata),
                .head_o     (head[gi]),
                .empty_o    (fifo_empty[gi]),
                .full_o     (req_full[gi]),
                .level_o    (req_level[gi*LVL_W +: LVL_W]),
                .overflow_o (fifo_ovf[gi])
            );
        end
    endgenerate

    // A FIFO being flushed this cycle is not a candidate for a new grant
    assign avail = ~fifo_empty & ~req_flush;

    // Round-robin scan starting at rr_q, wrapping
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(rr_q) + k) % NUM_REQ);
            if (!hit && avail[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    // Next-state logic for grant, command presentation and hold timeout
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        cmd_d         = cmd_q;
        last_d        = last_q;
        cmd_valid_d   = cmd_valid_q;
        flush_pend_d  = flush_pend_q;
        cnt_d         = cnt_q;
        fifo_pop      = '0;
        timeout_ev    = '0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    grant_valid_d = 1'b1;
                    grant_d       = pick;
                    rr_d          = IDW'((int'(pick) + 1) % NUM_REQ);
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                if (req_flush[grant_q]) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (!fifo_empty[grant_q]) begin
                    cmd_d        = head[grant_q].cmd;
                    last_d       = head[grant_q].last;
                    cmd_valid_d  = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = PRESENT;
                end else begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            PRESENT: begin
                // The blitter is mid-handshake: a flush only takes effect at next_cmd
                if (next_cmd) begin
                    cmd_valid_d = 1'b0;
                    if (flush_pend_q || req_flush[grant_q]) begin
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
                    end else begin
                        fifo_pop[grant_q] = 1'b1;
                        if (last_q) begin
                            grant_valid_d = 1'b0;
                            state_d       = IDLE;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end else if (req_flush[grant_q]) begin
                    flush_pend_d = 1'b1;
                end
            end
            HOLD: begin
                if (req_flush[grant_q]) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (req_push[grant_q]) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else if (cnt_q == TO_LAST) begin
                    timeout_ev[grant_q] = 1'b1;
                    grant_valid_d       = 1'b0;
                    state_d             = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_q       <= '0;
            rr_q          <= '0;
            cmd_q         <= '0;
            last_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            flush_pend_q  <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
            cmd_q         <= cmd_d;
            last_q        <= last_d;
            cmd_valid_q   <= cmd_valid_d;
            flush_pend_q  <= flush_pend_d;
            cnt_q         <= cnt_d;
        end
    end

    // Sticky error flags; a new event in the clearing cycle survives the clear
    always_ff @(posedge clock) begin
        if (reset) begin
            err_overflow_q <= '0;
            err_timeout_q  <= '0;
            err_protocol_q <= 1'b0;
        end else begin
            err_overflow_q <= (err_overflow_q & ~{NUM_REQ{err_clear}}) | fifo_ovf;
            err_timeout_q  <= (err_timeout_q & ~{NUM_REQ{err_clear}}) | timeout_ev;
            err_protocol_q <= (err_protocol_q & ~err_clear) | (next_cmd & ~cmd_valid_q);
        end
    end

    assign cmd          = cmd_q;
    assign cmd_valid    = cmd_valid_q;
    assign grant_valid  = grant_valid_q;
    assign grant_id     = 2'(grant_q);
    assign err_overflow = err_overflow_q;
    assign err_timeout  = err_timeout_q;
    assign err_protocol = err_protocol_q;

endmodule

// File: tb/tb_blit_cmd_arbiter.sv
// Bench for blit_cmd_arbiter: a vector table for FIFO/error/handshake steps,
// hand sequences for the multi-cycle corners, and randomized command groups
// checked against a group-level round-robin reference model.
module tb_blit_cmd_arbiter;

    localparam int NREQ = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ*96-1:0]    req_cmd = '0;
    logic [NREQ-1:0]       req_last = '0, req_push = '0, req_flush = '0;
    logic [NREQ-1:0]       req_full;
    logic [NREQ*5-1:0]     req_level;
    logic [95:0]           cmd;
    logic                  cmd_valid;
    logic                  next_cmd = 1'b0;
    logic                  grant_valid;
    logic [1:0]            grant_id;
    logic [NREQ-1:0]       err_overflow, err_timeout;
    logic                  err_protocol;
    logic                  err_clear = 1'b0;

    always #5 clock = ~clock;

    blit_cmd_arbiter #(.NUM_REQ(NREQ), .DEPTH(16), .HOLD_TIMEOUT(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_cmd      (req_cmd),
        .req_last     (req_last),
        .req_push     (req_push),
        .req_flush    (req_flush),
        .req_full     (req_full),
        .req_level    (req_level),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .next_cmd     (next_cmd),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .err_protocol (err_protocol),
        .err_clear    (err_clear)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [95:0] c;
        logic        last;
    } ent_t;

    // Reference model: per-requester queues of pushed-but-unconsumed commands
    ent_t q0[$], q1[$];
    ent_t l0[$], l1[$];

    typedef struct {
        logic [1:0] push;
        logic       last;
        logic [1:0] flush;
        logic       nxt;
        logic       clr;
        logic [4:0] lv0;
        logic [4:0] lv1;
        logic       cv;
        logic       gv;
        logic       ep;
    } vec_t;

    localparam int NV = 19;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; pulse inputs are dropped just after the edge
    task automatic cycle();
        @(posedge clock);
        #1;
        req_push  = '0;
        req_flush = '0;
        next_cmd  = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic push(input int i, input logic [95:0] c, input logic l);
        req_push[i]          = 1'b1;
        req_cmd[96*i +: 96]  = c;
        req_last[i]          = l;
    endtask

    function automatic logic [95:0] mk(input logic [7:0] op, input logic [31:0] a1,
                                       input logic [31:0] a2);
        return {a2, a1, 24'h0, op};
    endfunction

    task automatic wait_cv(input string name, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (cmd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: cmd_valid did not rise within 64 cycles", name);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd"}, cmd, 96'h0);
        chk({tag, "_cmd_valid"}, 96'(cmd_valid), 96'h0);
        chk({tag, "_grant_valid"}, 96'(grant_valid), 96'h0);
        chk({tag, "_grant_id"}, 96'(grant_id), 96'h0);
        chk({tag, "_err_overflow"}, 96'(err_overflow), 96'h0);
        chk({tag, "_err_timeout"}, 96'(err_timeout), 96'h0);
        chk({tag, "_err_protocol"}, 96'(err_protocol), 96'h0);
        chk({tag, "_req_level"}, 96'(req_level), 96'h0);
        chk({tag, "_req_full"}, 96'(req_full), 96'h0);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    initial begin
        bit          ok;
        int          rr_m, cur, n, mx;
        ent_t        e;
        logic [95:0] c0, c1;

        // ---------------- vector table (from reset) ----------------
        //            push   last  flush  nxt   clr   lv0   lv1   cv    gv    ep
        tv[0]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        tv[1]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0};
        tv[9]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0};
        tv[10] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0};
        tv[11] = '{2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        tv[12] = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        tv[13] = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        tv[14] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        tv[15] = '{2'b11, 1'b1, 2'b10, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0};
        tv[16] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0};
        tv[17] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0};
        tv[18] = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};

        do_reset();
        check_reset_values("reset");

        for (int k = 0; k < NV; k++) begin
            req_cmd   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            req_push  = tv[k].push;
            req_last  = {NREQ{tv[k].last}};
            req_flush = tv[k].flush;
            next_cmd  = tv[k].nxt;
            err_clear = tv[k].clr;
            cycle();
            chk($sformatf("vec%0d_level0", k), 96'(req_level[4:0]), 96'(tv[k].lv0));
            chk($sformatf("vec%0d_level1", k), 96'(req_level[9:5]), 96'(tv[k].lv1));
            chk($sformatf("vec%0d_cmd_valid", k), 96'(cmd_valid), 96'(tv[k].cv));
            chk($sformatf("vec%0d_grant_valid", k), 96'(grant_valid), 96'(tv[k].gv));
            chk($sformatf("vec%0d_err_protocol", k), 96'(err_protocol), 96'(tv[k].ep));
            chk($sformatf("vec%0d_err_overflow", k), 96'(err_overflow), 96'h0);
            $display("vector %0d applied: level0=%0d level1=%0d cmd_valid=%0b grant_valid=%0b",
                     k, req_level[4:0], req_level[9:5], cmd_valid, grant_valid);
        end

        // ---------------- single group, latency ----------------
        do_reset();
        push(0, mk(8'h04, 32'd5, 32'd0), 1'b0);
        cycle();
        chk("single_cv_edge1", 96'(cmd_valid), 96'h0);
        push(0, mk(8'h05, 32'h10, 32'h20), 1'b1);
        cycle();
        chk("single_cv_edge2", 96'(cmd_valid), 96'h0);
        cycle();
        chk("single_cv_edge3", 96'(cmd_valid), 96'h1);
        chk("single_opcode1", 96'(cmd[7:0]), 96'h04);
        chk("single_cmd1", cmd, mk(8'h04, 32'd5, 32'd0));
        chk("single_gid1", 96'(grant_id), 96'h0);
        cycle();
        cycle();
        chk("single_cv_stable", 96'(cmd_valid), 96'h1);
        next_cmd = 1'b1;
        cycle();
        chk("single_cv_drop", 96'(cmd_valid), 96'h0);
        chk("single_gv_mid", 96'(grant_valid), 96'h1);
        wait_cv("single_wait2", ok);
        chk("single_opcode2", 96'(cmd[7:0]), 96'h05);
        chk("single_gid2", 96'(grant_id), 96'h0);
        cycle();
        cycle();
        next_cmd = 1'b1;
        cycle();
        chk("single_gv_end", 96'(grant_valid), 96'h0);
        chk("single_cv_end", 96'(cmd_valid), 96'h0);
        $display("single group done");

        // ---------------- hold timeout ----------------
        do_reset();
        c0 = mk(8'h01, 32'hA, 32'hB);
        c1 = mk(8'h02, 32'hC, 32'hD);
        push(0, c0, 1'b0);
        cycle();
        push(1, c1, 1'b1);
        cycle();
        wait_cv("hold_wait0", ok);
        chk("hold_cmd0", cmd, c0);
        next_cmd = 1'b1;
        cycle();               // consumed, back to fetching the next req0 command
        cycle();               // FIFO empty, grant held
        for (int t = 0; t < 15; t++) cycle();
        chk("hold_timeout_early", 96'(err_timeout), 96'h0);
        chk("hold_gv_early", 96'(grant_valid), 96'h1);
        cycle();
        chk("hold_timeout", 96'(err_timeout), 96'h1);
        chk("hold_gv_revoked", 96'(grant_valid), 96'h0);
        cycle();
        chk("hold_regrant_gv", 96'(grant_valid), 96'h1);
        chk("hold_regrant_gid", 96'(grant_id), 96'h1);
        wait_cv("hold_wait1", ok);
        chk("hold_cmd1", cmd, c1);
        next_cmd = 1'b1;
        cycle();
        chk("hold_gv_end", 96'(grant_valid), 96'h0);
        err_clear = 1'b1;
        cycle();
        chk("hold_timeout_clear", 96'(err_timeout), 96'h0);
        $display("hold timeout done");

        // ---------------- overflow and flush during PRESENT ----------------
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(0, mk(8'h03, 32'(i), 32'h0), 1'b0);
            cycle();
            if (i == 15) begin
                chk("ovf_level16", 96'(req_level[4:0]), 96'd16);
                chk("ovf_full", 96'(req_full), 96'h1);
                chk("ovf_not_yet", 96'(err_overflow), 96'h0);
            end
        end
        chk("ovf_flag", 96'(err_overflow), 96'h1);
        chk("ovf_level_kept", 96'(req_level[4:0]), 96'd16);
        chk("ovf_cv", 96'(cmd_valid), 96'h1);
        req_flush[0] = 1'b1;
        cycle();
        chk("flush_level", 96'(req_level[4:0]), 96'd0);
        chk("flush_full", 96'(req_full), 96'h0);
        chk("flush_cv_held", 96'(cmd_valid), 96'h1);
        chk("flush_cmd_held", cmd, mk(8'h03, 32'd0, 32'h0));
        cycle();
        cycle();
        chk("flush_cv_still", 96'(cmd_valid), 96'h1);
        next_cmd = 1'b1;
        cycle();
        chk("flush_cv_drop", 96'(cmd_valid), 96'h0);
        chk("flush_gv_drop", 96'(grant_valid), 96'h0);
        chk("flush_level_end", 96'(req_level[4:0]), 96'd0);
        $display("overflow and flush done");

        // ---------------- protocol error and reset mid-group ----------------
        do_reset();
        next_cmd = 1'b1;
        cycle();
        chk("proto_err", 96'(err_protocol), 96'h1);
        push(0, mk(8'h06, 32'h1, 32'h2), 1'b0);
        cycle();
        push(0, mk(8'h07, 32'h3, 32'h4), 1'b1);
        cycle();
        wait_cv("midreset_wait", ok);
        reset = 1'b1;
        cycle();
        check_reset_values("midreset");
        reset = 1'b0;
        $display("protocol error and reset done");

        // ---------------- randomized groups vs reference model ----------------
        do_reset();
        rr_m = 0;
        for (int r = 0; r < 12; r++) begin
            l0.delete();
            l1.delete();
            for (int rq = 0; rq < NREQ; rq++) begin
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) begin
                    mx = $urandom_range(1, 3);
                    for (int k = 0; k < mx; k++) begin
                        e.c    = {$urandom, $urandom, 24'h0, 8'($urandom_range(0, 7))};
                        e.last = (k == mx - 1);
                        if (rq == 0) begin l0.push_back(e); q0.push_back(e); end
                        else         begin l1.push_back(e); q1.push_back(e); end
                    end
                end
            end
            mx = (l0.size() > l1.size()) ? l0.size() : l1.size();
            for (int t = 0; t < mx; t++) begin
                if (t < l0.size()) push(0, l0[t].c, l0[t].last);
                if (t < l1.size()) push(1, l1[t].c, l1[t].last);
                cycle();
            end
            chk($sformatf("rnd%0d_level0", r), 96'(req_level[4:0]), 96'(q0.size()));
            chk($sformatf("rnd%0d_level1", r), 96'(req_level[9:5]), 96'(q1.size()));

            cur = -1;
            while (q0.size() + q1.size() > 0) begin
                if (cur < 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (cur < 0 && qsize((rr_m + k) % NREQ) > 0) cur = (rr_m + k) % NREQ;
                    end
                end
                wait_cv($sformatf("rnd%0d_wait", r), ok);
                if (!ok) break;
                e = (cur == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rnd%0d_gid", r), 96'(grant_id), 96'(cur));
                chk($sformatf("rnd%0d_cmd", r), cmd, e.c);
                $display("round %0d: requester %0d issued cmd %h last=%0b", r, cur, cmd, e.last);
                repeat ($urandom_range(0, 3)) cycle();
                next_cmd = 1'b1;
                cycle();
                if (e.last) begin
                    rr_m = (cur + 1) % NREQ;
                    cur  = -1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    next_cmd = 1'b1;
                    cycle();
                    chk($sformatf("rnd%0d_proto_set", r), 96'(err_protocol), 96'h1);
                    err_clear = 1'b1;
                    cycle();
                    chk($sformatf("rnd%0d_proto_clr", r), 96'(err_protocol), 96'h0);
                end
            end
            q0.delete();
            q1.delete();
            repeat (3) cycle();
            chk($sformatf("rnd%0d_idle_gv", r), 96'(grant_valid), 96'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
